fma_port_arb: RTL
=================

Name: fma_port_arb

Overview:
- Arbitrated front end for the shared 8-lane FMA array.
- Several operator controllers (SiLU, softmax, RMSNorm, ...) each raise a busy flag and drive mode/a/b/c lane bundles; this block grants the array to exactly one controller at a time and muxes that client's operands onto the array inputs.
- Tracks each issued op through the array's fixed latency and returns a per-client response-valid strobe alongside the broadcast array result.
- Holds a new grant until the array pipeline has drained.

Parameters:
N_CLI, 4, number of requesting controllers (2..8)
LANES, 8, FMA lanes per issue
BW_FP, 17, custom float width per lane (8-bit exponent, 9-bit mantissa field)
LAT, 2, cycles from operand sample at the array to valid fma_out (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
cli_busy  in  N_CLI  per-client busy/request level; high for whole operation
cli_mode  in  N_CLI*LANES*5  per-client lane mode; all-zero lane = no op
cli_a  in  N_CLI*LANES*BW_FP  per-client operand a
cli_b  in  N_CLI*LANES*BW_FP  per-client operand b
cli_c  in  N_CLI*LANES*BW_FP  per-client operand c
fma_mode  out  LANES*5  to FMA array
fma_a  out  LANES*BW_FP  to FMA array
fma_b  out  LANES*BW_FP  to FMA array
fma_c  out  LANES*BW_FP  to FMA array
fma_out  in  LANES*BW_FP  array result, valid LAT cycles after issue
cli_grant  out  N_CLI  one-hot registered grant
cli_rsp_valid  out  N_CLI  one-hot pulse, fma_out belongs to that client this cycle
rsp_data  out  LANES*BW_FP  fma_out passthrough (combinational)
err_conflict  out  1  sticky: non-granted client drove nonzero mode

Behaviour:
- Reset values: cli_grant=0, cli_rsp_valid=0, err_conflict=0, FSM=IDLE, issue pipe cleared, rr pointer=0. fma_* outputs read 0 whenever no grant is held.
- Reset is asynchronous and may arrive mid-operation. All in-flight tracking is discarded; no rsp_valid is emitted for ops issued before reset.
- FSM states: IDLE, OWN, DRAIN.
  - IDLE: if any cli_busy is set, pick a winner, register cli_grant and go to OWN. The grant is visible the cycle after busy is first sampled, matching controllers that issue their first op one cycle after busy rises.
  - OWN: fma_mode/a/b/c are combinationally muxed from the owner; other clients are ignored. When the owner's busy is sampled low, cli_grant clears next cycle and the FSM goes to DRAIN.
  - DRAIN: stay until the issue pipe is empty, then return to IDLE. New requests are never granted in DRAIN, even when busy is simultaneously high on another client.
  - An owner that deasserts and reasserts busy while in DRAIN re-arbitrates normally from IDLE.
- Issue tracking:
  - A LAT-deep shift register of {valid, owner_idx}.
  - valid = granted and fma_mode != 0 in that cycle.
  - On exit, cli_rsp_valid[owner_idx] pulses for 1 cycle, aligned with the matching fma_out.
  - Back-to-back issues every cycle are supported; pulses are then consecutive.
- err_conflict:
  - Set when any client without grant (or any client in IDLE/DRAIN) has nonzero cli_mode while its busy is low.
  - Also set when a non-owner has nonzero mode in OWN.
  - Cleared only by reset.
- Arbitration is single-cycle and never grants more than one client. If no client is busy, the FSM remains in IDLE.
- Winner selection: fixed priority, lowest index wins (see optional feature).
- No arithmetic is performed. Widths pass through unchanged.

Optional Feature:
FMA_ARB_ROUND_ROBIN_EN
- Defined: winner is the first busy client at or after rr pointer, scanning upward with wrap; rr pointer updates to winner+1 (mod N_CLI) on each grant.
- Undefined: fixed priority, lowest busy index wins; no rr pointer logic.

Test Plan:
- Single client: client 1 busy high for 18 cycles, issues mode 5'b00100 on cycles 1..16 -> cli_grant=4'b0010 from cycle 1; cli_rsp_valid[1] pulses cycles 3..18; return to IDLE after drain; fma_* zero afterwards.
- Contention: clients 0 and 2 busy the same cycle -> client 0 granted (fixed priority). Client 2 is granted only after client 0 drops busy and LAT drain cycles elapse; no rsp pulse is ever attributed to client 2 before its grant.
- Round robin (macro defined): clients 0..3 continuously busy, each drops busy after 4 issues -> grant order 0,1,2,3,0.
- Conflict: client 3 drives nonzero mode without busy while client 0 owns -> err_conflict=1 and stays 1; fma_* still carry client 0 values.
- Reset mid-op: assert rst_n low 1 cycle after the 2nd issue -> no cli_rsp_valid afterwards, grant=0, FSM IDLE; a fresh request after release is granted normally.
- Gap issues with LAT=3: owner issues on cycles 1,4,5 -> rsp_valid on cycles 4,7,8 only.

Source files
------------

// File: rtl/fma_port_arb_if.sv
// Handshake/data bundle between operator controllers, the arbiter
// and the shared FMA array.
`timescale 1ns/1ps
interface fma_port_arb_if #(
  parameter int N_CLI = 4,
  parameter int LANES = 8,
  parameter int BW_FP = 17
);
  localparam int MW = LANES * 5;
  localparam int DW = LANES * BW_FP;

  logic [N_CLI-1:0]    cli_busy;
  logic [N_CLI*MW-1:0] cli_mode;
  logic [N_CLI*DW-1:0] cli_a;
  logic [N_CLI*DW-1:0] cli_b;
  logic [N_CLI*DW-1:0] cli_c;
  logic [MW-1:0]       fma_mode;
  logic [DW-1:0]       fma_a;
  logic [DW-1:0]       fma_b;
  logic [DW-1:0]       fma_c;
  logic [DW-1:0]       fma_out;
  logic [N_CLI-1:0]    cli_grant;
  logic [N_CLI-1:0]    cli_rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                err_conflict;

  modport master (
    output cli_busy, cli_mode,
    output cli_a, cli_b, cli_c,
    output fma_out,
    input  fma_mode, fma_a,
    input  fma_b, fma_c,
    input  cli_grant, cli_rsp_valid,
    input  rsp_data, err_conflict
  );

  modport slave (
    input  cli_busy, cli_mode,
    input  cli_a, cli_b, cli_c,
    input  fma_out,
    output fma_mode, fma_a,
    output fma_b, fma_c,
    output cli_grant, cli_rsp_valid,
    output rsp_data, err_conflict
  );
endinterface

// File: rtl/fma_port_arb.sv
// Shared FMA array arbiter with issue tracking and response routing.
// Optional macro FMA_ARB_ROUND_ROBIN_EN selects round-robin winners.
`timescale 1ns/1ps
module fma_port_arb #(
  parameter int N_CLI = 4,
  parameter int LANES = 8,
  parameter int BW_FP = 17,
  parameter int LAT   = 2
) (
  input logic           clk,
  input logic           rst_n,
  fma_port_arb_if.slave bus
);
  localparam int MW = LANES * 5;
  localparam int DW = LANES * BW_FP;
  localparam int IW = $clog2(N_CLI);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [N_CLI-1:0] r_grant;
  logic [N_CLI-1:0] w_grant_nx;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    w_owner_nx;
  logic [IW-1:0]    w_win;
  logic [LAT-1:0]   r_pv;
  logic [IW-1:0]    r_pidx [LAT];
  logic             r_err;
  logic             w_conf;
  logic             w_own;
  logic             w_issue;
  logic             w_req;

  assign w_own = (r_state == S_OWN);
  assign w_req = |bus.cli_busy;

`ifdef FMA_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_rr;
  logic [IW:0]   w_j;

  // scan downward so the last hit is the first busy at/after r_rr
  always_comb begin
    w_win = '0;
    w_j   = '0;
    for (int k = N_CLI - 1; k >= 0; k--) begin
      w_j = {1'b0, r_rr} + (IW+1)'(k);
      if (w_j >= (IW+1)'(N_CLI))
        w_j = w_j - (IW+1)'(N_CLI);
      if (bus.cli_busy[w_j[IW-1:0]])
        w_win = w_j[IW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rr <= '0;
    else if (r_state == S_IDLE && w_req)
      r_rr <= (w_win == IW'(N_CLI - 1)) ?
              '0 : w_win + IW'(1);
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = N_CLI - 1; i >= 0; i--)
      if (bus.cli_busy[i])
        w_win = IW'(i);
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_owner_nx = r_owner;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nx        = S_OWN;
          w_grant_nx        = '0;
          w_grant_nx[w_win] = 1'b1;
          w_owner_nx        = w_win;
        end
      end
      S_OWN: begin
        if (!bus.cli_busy[r_owner]) begin
          w_state_nx = S_DRAIN;
          w_grant_nx = '0;
        end
      end
      S_DRAIN: begin
        if (r_pv == '0)
          w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_owner <= w_owner_nx;
    end
  end

  always_comb begin
    bus.fma_mode = '0;
    bus.fma_a    = '0;
    bus.fma_b    = '0;
    bus.fma_c    = '0;
    if (w_own) begin
      bus.fma_mode =
        bus.cli_mode[int'(r_owner)*MW +: MW];
      bus.fma_a =
        bus.cli_a[int'(r_owner)*DW +: DW];
      bus.fma_b =
        bus.cli_b[int'(r_owner)*DW +: DW];
      bus.fma_c =
        bus.cli_c[int'(r_owner)*DW +: DW];
    end
  end

  assign w_issue = w_own && (bus.fma_mode != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int k = 0; k < LAT; k++)
        r_pidx[k] <= '0;
    end else begin
      r_pv[0]   <= w_issue;
      r_pidx[0] <= r_owner;
      for (int k = 1; k < LAT; k++) begin
        r_pv[k]   <= r_pv[k-1];
        r_pidx[k] <= r_pidx[k-1];
      end
    end
  end

  always_comb begin
    bus.cli_rsp_valid = '0;
    if (r_pv[LAT-1])
      bus.cli_rsp_valid[r_pidx[LAT-1]] = 1'b1;
  end

  assign bus.rsp_data = bus.fma_out;

  // a busy client may pre-drive mode while waiting, except during OWN
  always_comb begin
    w_conf = 1'b0;
    for (int i = 0; i < N_CLI; i++) begin
      if ((bus.cli_mode[i*MW +: MW] != '0) &&
          !(w_own && r_owner == IW'(i)) &&
          (w_own || !bus.cli_busy[i]))
        w_conf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_conf)
      r_err <= 1'b1;
  end

  assign bus.cli_grant    = r_grant;
  assign bus.err_conflict = r_err;
endmodule
